// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit scanned 7-segment display: font,
// converter state encodings, digit slot indices and special codes.
package fnd_pkg;

  // digit codes beyond 0-9
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;

  // largest legal minute/second value
  localparam logic [5:0] FIELD_MAX = 6'd59;

  // converter states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MIN  = 2'd1;
  localparam logic [1:0] ST_SEC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // digit slots, com[0] is the rightmost digit
  localparam logic [1:0] IDX_SEC_O = 2'd0;
  localparam logic [1:0] IDX_SEC_T = 2'd1;
  localparam logic [1:0] IDX_MIN_O = 2'd2;
  localparam logic [1:0] IDX_MIN_T = 2'd3;

  // font, active-high {dp,g,f,e,d,c,b,a}; polarity is applied at the pins
  localparam logic [7:0] FONT_0     = 8'h3F;
  localparam logic [7:0] FONT_1     = 8'h06;
  localparam logic [7:0] FONT_2     = 8'h5B;
  localparam logic [7:0] FONT_3     = 8'h4F;
  localparam logic [7:0] FONT_4     = 8'h66;
  localparam logic [7:0] FONT_5     = 8'h6D;
  localparam logic [7:0] FONT_6     = 8'h7D;
  localparam logic [7:0] FONT_7     = 8'h07;
  localparam logic [7:0] FONT_8     = 8'h7F;
  localparam logic [7:0] FONT_9     = 8'h6F;
  localparam logic [7:0] FONT_DASH  = 8'h40;
  localparam logic [7:0] FONT_BLANK = 8'h00;

  function automatic logic [7:0] seg_font(input logic [3:0] code);
    case (code)
      4'd0:      return FONT_0;
      4'd1:      return FONT_1;
      4'd2:      return FONT_2;
      4'd3:      return FONT_3;
      4'd4:      return FONT_4;
      4'd5:      return FONT_5;
      4'd6:      return FONT_6;
      4'd7:      return FONT_7;
      4'd8:      return FONT_8;
      4'd9:      return FONT_9;
      CODE_DASH: return FONT_DASH;
      default:   return FONT_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_conv_60.sv
// Sequential subtract-10 binary-to-BCD converter for a minute/second pair.
// Outputs double as the shadow buffer: they hold the last full result.
module bcd_conv_60
  import fnd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] min_bin,
  input  logic [5:0] sec_bin,
  output logic       done,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o
);

  logic [1:0] state;
  logic [5:0] work;
  logic [3:0] tens;

  assign done = (state == ST_DONE);

  // one subtract-10 step per cycle; a field above 59 skips straight to DASH
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      work  <= '0;
      tens  <= '0;
      min_t <= '0;
      min_o <= '0;
      sec_t <= '0;
      sec_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work  <= min_bin;
            tens  <= '0;
            state <= ST_MIN;
          end
        end
        ST_MIN: begin
          if (min_bin > FIELD_MAX) begin
            min_t <= CODE_DASH;
            min_o <= CODE_DASH;
            work  <= sec_bin;
            tens  <= '0;
            state <= ST_SEC;
          end else if (work >= 6'd10) begin
            work <= work - 6'd10;
            tens <= tens + 4'd1;
          end else begin
            min_t <= tens;
            min_o <= work[3:0];
            work  <= sec_bin;
            tens  <= '0;
            state <= ST_SEC;
          end
        end
        ST_SEC: begin
          if (sec_bin > FIELD_MAX) begin
            sec_t <= CODE_DASH;
            sec_o <= CODE_DASH;
            state <= ST_DONE;
          end else if (work >= 6'd10) begin
            work <= work - 6'd10;
            tens <= tens + 4'd1;
          end else begin
            sec_t <= tens;
            sec_o <= work[3:0];
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_4digit.sv
// 4-digit multiplexed 7-segment driver for MM:SS with frame-synchronous
// capture, background BCD conversion and a double-buffered display.
module fnd_scan_4digit
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter bit COM_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       dp_in,
  output logic [3:0] com,
  output logic [7:0] seg
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0] COM_OFF = COM_ACT_LOW ? 4'hF : 4'h0;
  localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic          frame_start;
  logic [5:0]    min_cap, sec_cap;
  logic          dp_cap, dp_sh, start_q, pend;
  logic          conv_done;
  logic [3:0]    sh_mt, sh_mo, sh_st, sh_so;
  logic [3:0]    disp_mt, disp_mo, disp_st, disp_so;
  logic          disp_dp;
  logic [3:0]    code;
  logic          dp_on;
  logic [7:0]    seg_ah;
  logic [3:0]    com_ah;

  assign frame_start = (div == '0) && (idx == 2'd0);

  // slot divider and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (div == DW'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // frame-start capture; start is delayed a cycle so the converter sees the captured values
  always_ff @(posedge clk) begin
    if (rst) begin
      min_cap <= '0;
      sec_cap <= '0;
      dp_cap  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= frame_start;
      if (frame_start) begin
        min_cap <= min_in;
        sec_cap <= sec_in;
        dp_cap  <= dp_in;
      end
    end
  end

  bcd_conv_60 u_conv (
    .clk     (clk),
    .rst     (rst),
    .start   (start_q),
    .min_bin (min_cap),
    .sec_bin (sec_cap),
    .done    (conv_done),
    .min_t   (sh_mt),
    .min_o   (sh_mo),
    .sec_t   (sh_st),
    .sec_o   (sh_so)
  );

  // shadow-to-display commit, only ever at a frame start; a done on that same edge waits a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 1'b0;
      dp_sh   <= 1'b0;
      disp_mt <= '0;
      disp_mo <= '0;
      disp_st <= '0;
      disp_so <= '0;
      disp_dp <= 1'b0;
    end else begin
      if (conv_done) dp_sh <= dp_cap;
      if (frame_start && pend) begin
        disp_mt <= sh_mt;
        disp_mo <= sh_mo;
        disp_st <= sh_st;
        disp_so <= sh_so;
        disp_dp <= dp_sh;
      end
      if (conv_done)        pend <= 1'b1;
      else if (frame_start) pend <= 1'b0;
    end
  end

  // digit mux and font lookup for the current slot
  always_comb begin
    code  = disp_so;
    dp_on = 1'b0;
    case (idx)
      IDX_SEC_O: code = disp_so;
      IDX_SEC_T: code = disp_st;
      IDX_MIN_O: begin
        code  = disp_mo;
        dp_on = disp_dp;
      end
      default:   code = disp_mt;
    endcase
    seg_ah = seg_font(code) | {dp_on, 7'b0};
    com_ah = 4'b0001 << idx;
  end

  // registered pins; the first cycle of each slot is dark to avoid ghosting
  always_ff @(posedge clk) begin
    if (rst || div == '0) begin
      com <= COM_OFF;
      seg <= SEG_OFF;
    end else begin
      com <= COM_ACT_LOW ? ~com_ah : com_ah;
      seg <= SEG_ACT_LOW ? ~seg_ah : seg_ah;
    end
  end

endmodule

// File: tb/tb_fnd_scan_4digit.sv
// Self-checking bench: a frame-level model records what was on the inputs
// at each frame start and predicts every pin value cycle by cycle.
module tb_fnd_scan_4digit;

  localparam int S  = 16;
  localparam int FR = 4 * S;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] min_in = '0;
  logic [5:0] sec_in = '0;
  logic       dp_in = 1'b0;
  logic [3:0] com;
  logic [7:0] seg;

  int npass = 0;
  int ntot  = 0;
  int pos   = 0;  // operating clock edges since reset release
  int cap_min [0:255];
  int cap_sec [0:255];
  bit cap_dp  [0:255];

  fnd_scan_4digit #(.SCAN_DIV(S), .COM_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .min_in (min_in),
    .sec_in (sec_in),
    .dp_in  (dp_in),
    .com    (com),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] font(int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;  default: return 8'h40;
    endcase
  endfunction

  // expected {com,seg} as seen now; pins show the slot position of the previous edge
  function automatic logic [11:0] expect_now();
    int p, f, ix, m, s, d;
    bit dp;
    logic [7:0] sg;
    logic [3:0] c;
    if (pos == 0) return 12'hFFF;
    p = pos - 1;
    if (p % S == 0) return 12'hFFF;
    ix = (p / S) % 4;
    f  = p / FR;
    if (f == 0) begin
      m = 0; s = 0; dp = 1'b0;
    end else begin
      m = cap_min[f-1]; s = cap_sec[f-1]; dp = cap_dp[f-1];
    end
    case (ix)
      0:       d = (s >= 60) ? 10 : s % 10;
      1:       d = (s >= 60) ? 10 : s / 10;
      2:       d = (m >= 60) ? 10 : m % 10;
      default: d = (m >= 60) ? 10 : m / 10;
    endcase
    sg = font(d);
    if (ix == 2 && dp) sg[7] = 1'b1;
    c = 4'b0001 << ix;
    c = ~c;
    return {c, ~sg};
  endfunction

  // advance one clock; the model records inputs the DUT samples at a frame start
  task automatic tick();
    if (!rst && (pos % FR == 0) && (pos / FR < 256)) begin
      cap_min[pos/FR] = int'(min_in);
      cap_sec[pos/FR] = int'(sec_in);
      cap_dp[pos/FR]  = dp_in;
    end
    @(posedge clk);
    if (rst) pos = 0;
    else     pos++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] e;
    rst = 1'b1; min_in = 6'd0; sec_in = 6'd0; dp_in = 1'b0;
    repeat (3) begin
      tick();
      ntot++;
      if ({com, seg} !== 12'hFFF) $display("FAIL reset_pins com=%b seg=%h want com=1111 seg=ff", com, seg);
      else npass++;
    end
    rst = 1'b0;
    for (int i = 0; i < FR + 2; i++) begin
      tick();
      e = expect_now();
      ntot++;
      if ({com, seg} !== e) $display("FAIL zero_display pos=%0d com=%b seg=%h want com=%b seg=%h", pos, com, seg, e[11:8], e[7:0]);
      else npass++;
    end
    ntot++;
    if (com !== 4'b1110 || seg !== 8'hC0) $display("FAIL idx0_div1_zero com=%b seg=%h want com=1110 seg=c0", com, seg);
    else npass++;
  endtask

  task automatic test_normal();
    logic [11:0] e;
    int k;
    min_in = 6'd59; sec_in = 6'd7; dp_in = 1'b1;
    while (pos % FR != 1) begin
      tick();
      e = expect_now();
      ntot++;
      if ({com, seg} !== e) $display("FAIL normal_pre pos=%0d com=%b seg=%h want com=%b seg=%h", pos, com, seg, e[11:8], e[7:0]);
      else npass++;
    end
    k = 0;
    while (dut.conv_done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    ntot++;
    if (dut.conv_done !== 1'b1 || k > 15) $display("FAIL conv_latency cycles=%0d done=%b want done within 15", k, dut.conv_done);
    else npass++;
    for (int i = 0; i < 3 * FR; i++) begin
      tick();
      e = expect_now();
      ntot++;
      if ({com, seg} !== e) $display("FAIL normal pos=%0d com=%b seg=%h want com=%b seg=%h", pos, com, seg, e[11:8], e[7:0]);
      else npass++;
    end
  endtask

  task automatic test_mid_frame();
    logic [11:0] e;
    while (pos % FR != S + 4) begin
      tick();
      e = expect_now();
      ntot++;
      if ({com, seg} !== e) $display("FAIL mid_pre pos=%0d com=%b seg=%h want com=%b seg=%h", pos, com, seg, e[11:8], e[7:0]);
      else npass++;
    end
    sec_in = 6'd8;
    for (int i = 0; i < 3 * FR; i++) begin
      tick();
      e = expect_now();
      ntot++;
      if ({com, seg} !== e) $display("FAIL mid_change pos=%0d com=%b seg=%h want com=%b seg=%h", pos, com, seg, e[11:8], e[7:0]);
      else npass++;
    end
  endtask

  task automatic test_out_of_range();
    logic [11:0] e;
    min_in = 6'd63; sec_in = 6'd25; dp_in = 1'b0;
    for (int i = 0; i < 3 * FR; i++) begin
      tick();
      e = expect_now();
      ntot++;
      if ({com, seg} !== e) $display("FAIL out_of_range pos=%0d com=%b seg=%h want com=%b seg=%h", pos, com, seg, e[11:8], e[7:0]);
      else npass++;
    end
    while (pos % FR != 2 * S + 2) tick();
    ntot++;
    if (com !== 4'b1011 || seg !== 8'hBF) $display("FAIL dash_idx2 com=%b seg=%h want com=1011 seg=bf", com, seg);
    else npass++;
    while (pos % FR != 3 * S + 2) tick();
    ntot++;
    if (com !== 4'b0111 || seg !== 8'hBF) $display("FAIL dash_idx3 com=%b seg=%h want com=0111 seg=bf", com, seg);
    else npass++;
    while (pos % FR != 2) tick();
    ntot++;
    if (com !== 4'b1110 || seg !== 8'h92) $display("FAIL sec_ones_5 com=%b seg=%h want com=1110 seg=92", com, seg);
    else npass++;
  endtask

  task automatic test_antighost();
    for (int i = 0; i < 3 * FR; i++) begin
      if (i % 37 == 5) begin
        min_in = 6'($urandom_range(0, 63));
        sec_in = 6'($urandom_range(0, 63));
        dp_in  = 1'($urandom_range(0, 1));
      end
      tick();
      if ((pos - 1) % S == 0) begin
        ntot++;
        if (com !== 4'hF || seg !== 8'hFF) $display("FAIL antighost pos=%0d com=%b seg=%h want com=1111 seg=ff", pos, com, seg);
        else npass++;
      end
    end
  endtask

  task automatic test_reset_conv();
    logic [11:0] e;
    while (pos % FR != 1) tick();
    min_in = 6'd42; sec_in = 6'd33; dp_in = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    ntot++;
    if ({com, seg} !== 12'hFFF) $display("FAIL reset_mid_conv com=%b seg=%h want com=1111 seg=ff", com, seg);
    else npass++;
    rst = 1'b0;
    min_in = 6'd12; sec_in = 6'd34; dp_in = 1'b0;
    for (int i = 0; i < 3 * FR; i++) begin
      tick();
      e = expect_now();
      ntot++;
      if ({com, seg} !== e) $display("FAIL after_reset pos=%0d com=%b seg=%h want com=%b seg=%h", pos, com, seg, e[11:8], e[7:0]);
      else npass++;
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    for (int i = 0; i < 8 * FR; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        min_in = 6'($urandom_range(0, 63));
        sec_in = 6'($urandom_range(0, 63));
        dp_in  = 1'($urandom_range(0, 1));
      end
      tick();
      e = expect_now();
      ntot++;
      if ({com, seg} !== e) $display("FAIL random pos=%0d com=%b seg=%h want com=%b seg=%h", pos, com, seg, e[11:8], e[7:0]);
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_mid_frame();
    test_out_of_range();
    test_antighost();
    test_reset_conv();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fnd_scan_4digit.md
# fnd_scan_4digit

Downstream display stage for the watch counters. It takes the minute and second values produced by the 0–59 pulse counters, converts each to two BCD digits with a small sequential converter, and drives a 4-digit multiplexed common-anode 7-segment display. The colon dot on the minute-ones digit follows the counters' half-period output.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clock cycles per digit slot. Must be ≥ 16.
- `COM_ACT_LOW`, default 1: digit-common enable polarity. 1 means active-low.
- `SEG_ACT_LOW`, default 1: segment polarity. 1 means active-low.

Ports:
- `clk` in 1: system clock. The block uses this single clock only.
- `rst` in 1: reset, synchronous and active-high.
- `min_in` in 6: minutes, binary. Legal range 0–59.
- `sec_in` in 6: seconds, binary. Legal range 0–59.
- `dp_in` in 1: colon request, driven by the seconds counter's half-period output.
- `com` out 4: digit enables. com[0] is seconds ones, com[3] is minutes tens.
- `seg` out 8: segments {dp,g,f,e,d,c,b,a}.

## Operation

- **Slot divider `div`:** counts 0..SCAN_DIV-1 and wraps. At each wrap, digit index `idx` advances 0→1→2→3→0.
- **Frame start:** the cycle where `div==0 && idx==0`. At frame start the block:
  - samples `min_in`, `sec_in` and `dp_in` into capture registers;
  - pulses `start` to the converter.
- **Converter FSM states:** IDLE, MIN, SEC, DONE.
  - IDLE→MIN on `start`.
  - MIN: if the working value is ≥ 10, subtract 10 and increment tens. Otherwise store tens and ones, load seconds, and go to SEC.
  - SEC: same step as MIN; when the value is < 10, store and go to DONE.
  - DONE→IDLE after one cycle, setting `pend`.
- **Out-of-range input (≥ 60):** both digits of that field hold code DASH (segment g only). The FSM skips subtraction for that field.
- **Double buffering:**
  - Converter results sit in a shadow buffer.
  - At the next frame start, if `pend` is set, the shadow is copied into the display buffer and `pend` clears.
  - The display buffer is never written mid-frame.
- **Digit map:**
  - idx0 = sec ones, idx1 = sec tens, idx2 = min ones, idx3 = min tens.
  - No leading-zero blanking.
- **Decimal point:** lit only on idx2, and only when the captured `dp_in` is 1. The captured `dp_in` goes through the same double buffer as the digits.
- **Anti-ghosting:** during `div==0` of every slot, all `com` lines are inactive and `seg` is all-off.
- **Reset:**
  - `div`, `idx`, FSM (IDLE), `pend` and all buffers are cleared. Display buffer = 0,0,0,0 with dp off.
  - `com` = all inactive (4'b1111 when COM_ACT_LOW), `seg` = all off (8'hFF when SEG_ACT_LOW).
  - Reset asserted mid-frame or mid-conversion aborts everything on that edge. No partial result is ever committed.
- **Simultaneous events:** `start` while the FSM is not IDLE cannot occur, because conversion finishes in ≤ 15 cycles and SCAN_DIV ≥ 16. A `pend` set on the same cycle as a frame start is committed at the following frame start.

## Timing

- `com` and `seg` are registered and change one cycle after `div`/`idx`.
- Slot k: `com` is active for cycles div = 1..SCAN_DIV-1. Frame length is 4·SCAN_DIV cycles.
- Conversion latency from frame start to `pend` is at most 2·6 + 3 = 15 cycles.
- Inputs are sampled at frame start F and first displayed in frame F+1, at idx0, div 1. End-to-end input-to-display latency is 4·SCAN_DIV + 2 cycles.
- Inputs changing between frame starts are ignored.
- Refresh at 50 MHz with default SCAN_DIV is 250 Hz per frame.

## Structure

- **Shared package `fnd_pkg`:**
  - 7-segment font constants: digits 0–9, DASH, BLANK, active-high form. Polarity is applied at the output.
  - Converter state encodings.
  - Digit-index constants.
  - Code DASH = 4'hA.
- **Sub-module `bcd_conv_60`:** the sequential subtract-10 converter.
  - Ports: `clk`, `rst`, `start`, `min_bin`, `sec_bin`, `done`, `min_t`, `min_o`, `sec_t`, `sec_o`.
- **Top:** divider, index, capture and double buffers, digit mux, font lookup, polarity.

## Test plan

- **Reset and zero display:** rst high 3 cycles then low, SCAN_DIV=16 → `com`=1111 and `seg`=FF during reset. Afterwards the display shows 0,0,0,0; slot idx0 enables `com`=1110 at div 1 with `seg` = font '0'.
- **Normal value:** `min_in`=59, `sec_in`=7, `dp_in`=1 held → from frame 2 the slots show 7, 0, 9 with dp, 5. The converter signals done within 15 cycles of frame start.
- **Mid-frame change:** `sec_in` changes 7→8 at idx1 of frame 2 → frames 2 and 3 still show 7; frame 4 shows 8.
- **Out of range:** `min_in`=63 → idx2 and idx3 show DASH (`seg`=8'hBF active-low). The seconds field is unaffected.
- **Anti-ghosting:** every div==0 cycle shows `com` all inactive and `seg` all-off, checked across 3 frames.
- **Reset during conversion:** rst asserted 5 cycles after frame start → the next frames show 0,0,0,0 until a fresh conversion commits. There is no stale `pend`.
